vga_timing_core: RTL and testbench

Parametrised, runtime-reconfigurable VESA timing generator and pixel pipeline; successor to the fixed 12-bit VGA output core. It generates hsync, vsync and active flags from free-running counters, issues pixel requests with x/y coordinates a configurable number of cycles ahead of need, and aligns returned colour data with the sync outputs. Timing changes are staged in shadow registers and applied only at a frame boundary. It sits between the frame source (framebuffer reader or pattern logic) and the VGA DAC pins.

---
 rtl/vga_timing_core.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_timing_core.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// vga_timing_core: VESA sync/active generator with frame-boundary config swap and pixel request/return alignment.
// Optional colour bars replace rgb_* when VGA_TIMING_CORE_TEST_PATTERN_EN is defined.
module vga_timing_core #(
  parameter int COLOR_W  = 4,
  parameter int CNT_W    = 12,
  parameter int PIPE_LAT = 2
) (
  input  logic               pxl_clk,
  input  logic               pxl_rst,
  input  logic [CNT_W-1:0]   horz_res,
  input  logic [CNT_W-1:0]   horz_front,
  input  logic [CNT_W-1:0]   horz_back,
  input  logic [CNT_W-1:0]   horz_sync_len,
  input  logic [CNT_W-1:0]   vert_res,
  input  logic [CNT_W-1:0]   vert_front,
  input  logic [CNT_W-1:0]   vert_back,
  input  logic [CNT_W-1:0]   vert_sync_len,
  input  logic               hsync_pol,
  input  logic               vsync_pol,
  input  logic               cfg_update,
  output logic               cfg_pending,
  output logic               cfg_error,
  output logic               pxl_req,
  output logic [CNT_W-1:0]   pxl_x,
  output logic [CNT_W-1:0]   pxl_y,
  input  logic [COLOR_W-1:0] rgb_red,
  input  logic [COLOR_W-1:0] rgb_green,
  input  logic [COLOR_W-1:0] rgb_blue,
  input  logic               test_pattern,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [COLOR_W-1:0] vga_red,
  output logic [COLOR_W-1:0] vga_green,
  output logic [COLOR_W-1:0] vga_blue,
  output logic               horz_active,
  output logic               vert_active,
  output logic               frame_active,
  output logic               line_start,
  output logic               frame_start
);
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] MAX_TOT = SW'(1) << CNT_W;

  typedef struct packed {
    logic [CNT_W-1:0] hres, hfront, hback, hsync;
    logic [CNT_W-1:0] vres, vfront, vback, vsync;
    logic             hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic       hs, vs, ha, va, ls, fs;
    logic [2:0] bar;
  } flg_t;

  function automatic logic [SW-1:0] zx(input logic [CNT_W-1:0] a);
    return {2'b00, a};
  endfunction

  cfg_t in_cfg, act_q, act_d, shd_q, shd_d;
  logic cfg_pending_q, cfg_pending_d, cfg_error_q, cfg_error_d;
  logic run_q, run_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  flg_t dly_q [1:PIPE_LAT+1];
  flg_t dly_d [1:PIPE_LAT+1];
  flg_t tap   [0:PIPE_LAT+1];
  flg_t flg0;

  logic [SW-1:0] hz, vz, h_sb, h_ae, h_tot, v_sb, v_ae, v_tot, in_htot, in_vtot;
  logic in_bad, h_last, v_last, ha0, va0;
  logic [CNT_W-1:0] cur_x, cur_y;
  logic [2:0] bar_idx;

  assign in_cfg = '{hres: horz_res, hfront: horz_front, hback: horz_back, hsync: horz_sync_len,
                    vres: vert_res, vfront: vert_front, vback: vert_back, vsync: vert_sync_len,
                    hpol: hsync_pol, vpol: vsync_pol};

  assign in_htot = zx(horz_res) + zx(horz_front) + zx(horz_back) + zx(horz_sync_len);
  assign in_vtot = zx(vert_res) + zx(vert_front) + zx(vert_back) + zx(vert_sync_len);
  assign in_bad  = (horz_res == '0) | (horz_front == '0) | (horz_back == '0) | (horz_sync_len == '0) |
                   (vert_res == '0) | (vert_front == '0) | (vert_back == '0) | (vert_sync_len == '0) |
                   (in_htot > MAX_TOT) | (in_vtot > MAX_TOT);

  // Line layout: sync, back porch, active, front porch.
  assign hz     = zx(h_cnt_q);
  assign vz     = zx(v_cnt_q);
  assign h_sb   = zx(act_q.hsync) + zx(act_q.hback);
  assign h_ae   = h_sb + zx(act_q.hres);
  assign h_tot  = h_ae + zx(act_q.hfront);
  assign v_sb   = zx(act_q.vsync) + zx(act_q.vback);
  assign v_ae   = v_sb + zx(act_q.vres);
  assign v_tot  = v_ae + zx(act_q.vfront);
  assign h_last = (hz == h_tot - SW'(1));
  assign v_last = (vz == v_tot - SW'(1));
  assign ha0    = (hz >= h_sb) & (hz < h_ae);
  assign va0    = (vz >= v_sb) & (vz < v_ae);
  assign cur_x  = CNT_W'(hz - h_sb);
  assign cur_y  = CNT_W'(vz - v_sb);

`ifdef VGA_TIMING_CORE_TEST_PATTERN_EN
  logic [SW-1:0] bar_w;
  always_comb begin
    bar_w   = (act_q.hres < CNT_W'(8)) ? SW'(1) : zx(act_q.hres >> 3);
    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (zx(cur_x) >= SW'(k) * bar_w) bar_idx = bar_idx + 3'd1;
  end
`else
  logic unused_tp;
  assign unused_tp = test_pattern;
  assign bar_idx   = '0;
`endif

  always_comb begin
    flg0     = '0;
    flg0.hs  = run_q & (hz < zx(act_q.hsync));
    flg0.vs  = run_q & (vz < zx(act_q.vsync));
    flg0.ha  = run_q & ha0;
    flg0.va  = run_q & va0;
    flg0.ls  = run_q & (h_cnt_q == '0);
    flg0.fs  = run_q & (h_cnt_q == '0) & (v_cnt_q == '0);
    flg0.bar = bar_idx;
  end

  always_comb begin
    tap[0] = flg0;
    for (int k = 1; k <= PIPE_LAT + 1; k++) tap[k] = dly_q[k];
    for (int k = 1; k <= PIPE_LAT + 1; k++) dly_d[k] = tap[k-1];
  end

  // Colour is sampled in the cycle the delayed request becomes due.
  always_comb begin
    rgb_d = '0;
    if (tap[PIPE_LAT].ha & tap[PIPE_LAT].va) begin
      rgb_d = {rgb_red, rgb_green, rgb_blue};
`ifdef VGA_TIMING_CORE_TEST_PATTERN_EN
      if (test_pattern)
        rgb_d = {{COLOR_W{tap[PIPE_LAT].bar[2]}}, {COLOR_W{tap[PIPE_LAT].bar[1]}},
                 {COLOR_W{tap[PIPE_LAT].bar[0]}}};
`endif
    end
  end

  always_comb begin
    act_d         = act_q;
    shd_d         = shd_q;
    cfg_pending_d = cfg_pending_q;
    cfg_error_d   = 1'b0;
    run_d         = 1'b1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    last_x_d      = pxl_req ? cur_x : last_x_q;
    last_y_d      = pxl_req ? cur_y : last_y_q;
    if (cfg_update) begin
      if (in_bad) cfg_error_d = 1'b1;
      else begin
        shd_d         = in_cfg;
        cfg_pending_d = 1'b1;
      end
    end
    if (run_q) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
      // A capture landing on the boundary itself bypasses the pending state.
      if (h_last & v_last) begin
        if (cfg_update & ~in_bad) begin
          act_d         = in_cfg;
          cfg_pending_d = 1'b0;
        end else if (cfg_pending_q) begin
          act_d         = shd_q;
          cfg_pending_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (pxl_rst) begin
      act_q         <= in_cfg;
      shd_q         <= in_cfg;
      cfg_pending_q <= 1'b0;
      cfg_error_q   <= 1'b0;
      run_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      last_x_q      <= '0;
      last_y_q      <= '0;
      rgb_q         <= '0;
      dly_q         <= '{default: '0};
    end else begin
      act_q         <= act_d;
      shd_q         <= shd_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_error_q   <= cfg_error_d;
      run_q         <= run_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      rgb_q         <= rgb_d;
      dly_q         <= dly_d;
    end
  end

  // Sync level is applied at the pins so a polarity swap re-encodes in-flight samples.
  assign vga_hsync    = ~(tap[PIPE_LAT+1].hs ^ act_q.hpol);
  assign vga_vsync    = ~(tap[PIPE_LAT+1].vs ^ act_q.vpol);
  assign horz_active  = tap[PIPE_LAT+1].ha;
  assign vert_active  = tap[PIPE_LAT+1].va;
  assign frame_active = tap[PIPE_LAT+1].ha & tap[PIPE_LAT+1].va;
  assign line_start   = tap[PIPE_LAT+1].ls;
  assign frame_start  = tap[PIPE_LAT+1].fs;
  assign vga_red      = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga_green    = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_blue     = rgb_q[COLOR_W-1:0];
  assign pxl_req      = run_q & ha0 & va0;
  assign pxl_x        = pxl_req ? cur_x : last_x_q;
  assign pxl_y        = pxl_req ? cur_y : last_y_q;
  assign cfg_pending  = cfg_pending_q;
  assign cfg_error    = cfg_error_q;
endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: random small timings, random colours and config traffic against a
// linear frame-position reference model.
module tb_vga_timing_core;
  localparam int COLOR_W  = 4;
  localparam int CNT_W    = 12;
  localparam int PIPE_LAT = 2;

  logic pxl_clk = 1'b0;
  logic pxl_rst;
  logic [CNT_W-1:0] horz_res, horz_front, horz_back, horz_sync_len;
  logic [CNT_W-1:0] vert_res, vert_front, vert_back, vert_sync_len;
  logic hsync_pol, vsync_pol, cfg_update, cfg_pending, cfg_error, pxl_req, test_pattern;
  logic [CNT_W-1:0] pxl_x, pxl_y;
  logic [COLOR_W-1:0] rgb_red, rgb_green, rgb_blue, vga_red, vga_green, vga_blue;
  logic vga_hsync, vga_vsync, horz_active, vert_active, frame_active, line_start, frame_start;

  always #5 pxl_clk = ~pxl_clk;

  vga_timing_core #(.COLOR_W(COLOR_W), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .pxl_clk(pxl_clk), .pxl_rst(pxl_rst),
    .horz_res(horz_res), .horz_front(horz_front), .horz_back(horz_back), .horz_sync_len(horz_sync_len),
    .vert_res(vert_res), .vert_front(vert_front), .vert_back(vert_back), .vert_sync_len(vert_sync_len),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .cfg_update(cfg_update),
    .cfg_pending(cfg_pending), .cfg_error(cfg_error),
    .pxl_req(pxl_req), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue), .test_pattern(test_pattern),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .horz_active(horz_active), .vert_active(vert_active), .frame_active(frame_active),
    .line_start(line_start), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [15:0] hres, hfront, hback, hsync, vres, vfront, vback, vsync;
    logic        hpol, vpol;
  } tcfg_t;

  typedef struct packed {
    logic        hs, vs, ha, va, ls, fs;
    logic [15:0] x, y;
  } stg_t;

  int n_cmp, n_bad;
  tcfg_t m_act, m_shd;
  logic m_pend, m_err;
  int m_p, cyc, last_x, last_y;
  stg_t hist [64];
  logic [11:0] rgb_hist [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int htot(input tcfg_t c);
    return int'(c.hres) + int'(c.hfront) + int'(c.hback) + int'(c.hsync);
  endfunction
  function automatic int vtot(input tcfg_t c);
    return int'(c.vres) + int'(c.vfront) + int'(c.vback) + int'(c.vsync);
  endfunction
  function automatic int ftot(input tcfg_t c);
    return htot(c) * vtot(c);
  endfunction

  function automatic logic cfg_ok(input tcfg_t c);
    if (c.hres == 0 || c.hfront == 0 || c.hback == 0 || c.hsync == 0) return 1'b0;
    if (c.vres == 0 || c.vfront == 0 || c.vback == 0 || c.vsync == 0) return 1'b0;
    return (htot(c) <= 4096) && (vtot(c) <= 4096);
  endfunction

  // Position within the frame is a single linear index; h/v fall out of div/mod.
  function automatic stg_t decode(input tcfg_t c, input int p);
    stg_t d;
    int h, v, hb, vb;
    h  = p % htot(c);
    v  = p / htot(c);
    hb = int'(c.hsync) + int'(c.hback);
    vb = int'(c.vsync) + int'(c.vback);
    d.hs = (h < int'(c.hsync));
    d.vs = (v < int'(c.vsync));
    d.ha = (h >= hb) && (h < hb + int'(c.hres));
    d.va = (v >= vb) && (v < vb + int'(c.vres));
    d.ls = (h == 0);
    d.fs = (p == 0);
    d.x  = 16'(h - hb);
    d.y  = 16'(v - vb);
    return d;
  endfunction

  function automatic tcfg_t rnd_cfg();
    tcfg_t r;
    r.hres   = 16'($urandom_range(1, 6));
    r.hfront = 16'($urandom_range(1, 4));
    r.hback  = 16'($urandom_range(1, 4));
    r.hsync  = 16'($urandom_range(1, 4));
    r.vres   = 16'($urandom_range(1, 4));
    r.vfront = 16'($urandom_range(1, 2));
    r.vback  = 16'($urandom_range(1, 2));
    r.vsync  = 16'($urandom_range(1, 2));
    r.hpol   = 1'($urandom_range(0, 1));
    r.vpol   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic tcfg_t corrupt(input tcfg_t c);
    tcfg_t r;
    r = c;
    case ($urandom_range(0, 7))
      0: r.hres = 0;   1: r.hfront = 0; 2: r.hback = 0; 3: r.hsync = 0;
      4: r.vres = 0;   5: r.vfront = 0; 6: r.vback = 0; default: r.vsync = 0;
    endcase
    return r;
  endfunction

  task automatic drive_cfg(input tcfg_t c);
    horz_res = c.hres[CNT_W-1:0];  horz_front = c.hfront[CNT_W-1:0];
    horz_back = c.hback[CNT_W-1:0]; horz_sync_len = c.hsync[CNT_W-1:0];
    vert_res = c.vres[CNT_W-1:0];  vert_front = c.vfront[CNT_W-1:0];
    vert_back = c.vback[CNT_W-1:0]; vert_sync_len = c.vsync[CNT_W-1:0];
    hsync_pol = c.hpol; vsync_pol = c.vpol;
  endtask

  // Check the current cycle, drive this cycle's inputs, advance the model and the clock.
  task automatic cycle(input logic upd, input tcfg_t nc);
    stg_t cur, o;
    logic [11:0] col, ecol;
    logic bad;
    cur = decode(m_act, m_p);
    hist[cyc % 64] = cur;
    if (cur.ha && cur.va) begin last_x = int'(cur.x); last_y = int'(cur.y); end
    chk("pxl_req", 32'(pxl_req), 32'(cur.ha && cur.va));
    chk("pxl_x", 32'(pxl_x), 32'(last_x));
    chk("pxl_y", 32'(pxl_y), 32'(last_y));
    o = '0;
    ecol = '0;
    if (cyc >= PIPE_LAT + 1) begin
      o = hist[(cyc - PIPE_LAT - 1) % 64];
      if (o.ha && o.va) ecol = rgb_hist[(cyc - 1) % 64];
    end
    chk("vga_hsync", 32'(vga_hsync), 32'(o.hs ? m_act.hpol : !m_act.hpol));
    chk("vga_vsync", 32'(vga_vsync), 32'(o.vs ? m_act.vpol : !m_act.vpol));
    chk("vga_rgb", 32'({vga_red, vga_green, vga_blue}), 32'(ecol));
    chk("horz_active", 32'(horz_active), 32'(o.ha));
    chk("vert_active", 32'(vert_active), 32'(o.va));
    chk("frame_active", 32'(frame_active), 32'(o.ha && o.va));
    chk("line_start", 32'(line_start), 32'(o.ls));
    chk("frame_start", 32'(frame_start), 32'(o.fs));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    chk("cfg_error", 32'(cfg_error), 32'(m_err));
    col = 12'($urandom);
    {rgb_red, rgb_green, rgb_blue} = col;
    rgb_hist[cyc % 64] = col;
    drive_cfg(upd ? nc : ($urandom_range(0, 1) ? corrupt(rnd_cfg()) : rnd_cfg()));
    cfg_update = upd;
    bad   = upd && !cfg_ok(nc);
    m_err = bad;
    if (upd && !bad) begin m_shd = nc; m_pend = 1'b1; end
    if (m_p == ftot(m_act) - 1) begin
      m_p = 0;
      if (upd && !bad) begin m_act = nc; m_pend = 1'b0; end
      else if (m_pend) begin m_act = m_shd; m_pend = 1'b0; end
    end else begin
      m_p++;
    end
    @(posedge pxl_clk); #1;
    cfg_update = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    tcfg_t z;
    z = '0;
    for (int i = 0; i < n; i++) cycle(1'b0, z);
  endtask

  task automatic wait_pos(input int target);
    int i;
    i = 0;
    while (m_p != target && i < 50000) begin run(1); i++; end
    if (m_p != target) begin
      n_cmp++; n_bad++;
      $error("FAIL wait_pos timeout observed=%0d expected=%0d", m_p, target);
    end
  endtask

  task automatic do_reset(input int n, input tcfg_t c);
    drive_cfg(c);
    cfg_update = 1'b0;
    pxl_rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge pxl_clk); #1;
      chk("rst_hsync", 32'(vga_hsync), 32'(!c.hpol));
      chk("rst_vsync", 32'(vga_vsync), 32'(!c.vpol));
      chk("rst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'(0));
      chk("rst_flags", 32'({horz_active, vert_active, frame_active, line_start, frame_start}), 32'(0));
      chk("rst_req", 32'({pxl_req, cfg_pending, cfg_error}), 32'(0));
      chk("rst_xy", 32'({pxl_x, pxl_y}), 32'(0));
    end
    pxl_rst = 1'b0;
    @(posedge pxl_clk); #1;
    m_act = c; m_shd = c; m_pend = 1'b0; m_err = 1'b0;
    m_p = 0; cyc = 0; last_x = 0; last_y = 0;
  endtask

  initial begin
    tcfg_t c0, nc;
    stg_t s;
    int t;
    n_cmp = 0; n_bad = 0; cyc = 0;
    pxl_rst = 1'b1; cfg_update = 1'b0; test_pattern = 1'b0;
    rgb_red = '0; rgb_green = '0; rgb_blue = '0;
    c0 = '{hres: 16'd8, hfront: 16'd2, hback: 16'd3, hsync: 16'd2,
           vres: 16'd4, vfront: 16'd1, vback: 16'd2, vsync: 16'd1, hpol: 1'b0, vpol: 1'b0};
    drive_cfg(c0);

    do_reset(3, c0);
    run(2 * ftot(c0) + 5);

    // Mid-frame capture waits for the boundary.
    wait_pos(7);
    nc = rnd_cfg();
    cycle(1'b1, nc);
    run(2 * ftot(c0) + 2 * ftot(nc));

    // Zero back porch is rejected.
    nc = m_act; nc.hback = 16'd0;
    wait_pos(3);
    cycle(1'b1, nc);
    run(ftot(m_act) + 4);

    // Capture in the boundary cycle itself.
    nc = rnd_cfg();
    wait_pos(ftot(m_act) - 1);
    cycle(1'b1, nc);
    run(2 * ftot(nc));

    // Exactly 2^CNT_W is legal, one more is not; the last valid capture wins.
    wait_pos(2);
    nc = m_act; nc.hres = 16'd4093; nc.hfront = 16'd1; nc.hback = 16'd1; nc.hsync = 16'd1;
    cycle(1'b1, nc);
    nc.hres = 16'd4094;
    cycle(1'b1, nc);
    nc = m_act; nc.vres = 16'd4095; nc.vfront = 16'd1; nc.vback = 16'd1; nc.vsync = 16'd1;
    cycle(1'b1, nc);
    nc = rnd_cfg();
    cycle(1'b1, nc);
    run(2 * ftot(m_act) + 2 * ftot(nc));

    // Reset while a line is actively being requested.
    t = 0;
    s = decode(m_act, m_p);
    while (!(s.ha && s.va) && t < 5000) begin run(1); s = decode(m_act, m_p); t++; end
    if (!(s.ha && s.va)) begin
      n_cmp++; n_bad++;
      $error("FAIL active_search timeout observed=%0d expected=%0d", t, 5000);
    end
    do_reset(2, rnd_cfg());
    run(ftot(m_act) + 10);

    for (int it = 0; it < 40; it++) begin
      nc = rnd_cfg();
      if ($urandom_range(0, 3) == 0) nc = corrupt(nc);
      if ($urandom_range(0, 2) == 0) wait_pos(ftot(m_act) - 1);
      else run($urandom_range(1, 60));
      cycle(1'b1, nc);
      run($urandom_range(0, 10));
    end
    run(2 * ftot(m_act) + 2 * ftot(m_shd));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
